alu_input_seq: RTL and testbench
================================

// Module: alu_input_seq
// PURPOSE
//  Operand/opcode entry sequencer sitting directly upstream of the 4-bit ALU on the board.
//  Operators set switches and press one key to load A, then B, then the opcode; the block
//  drives the ALU operand/ctrl inputs, then captures the ALU result and flags into registers.
//  Both keys are synchronised and debounced internally, so raw board buttons connect directly.
// PARAMETERS
//  W          4   operand width (matches ALU a/b/res)
//  OPW        3   opcode width (matches ALU ctrl)
//  DEB_CYCLES 2**20  cycles a synced key level must hold before it is accepted (sim: 4)
// PORTS
//  clk        in   1    system clock
//  rst        in   1    synchronous, active-high reset
//  sw         in   W    operand switches (raw, quasi-static)
//  op_sw      in   OPW  opcode switches
//  key_next   in   1    raw button, active-high: advance sequence
//  key_clr    in   1    raw button, active-high: abort/clear
//  alu_a      out  W    operand A to ALU (registered)
//  alu_b      out  W    operand B to ALU (registered)
//  alu_ctrl   out  OPW  opcode to ALU (registered)
//  alu_res    in   W    ALU result (combinational from alu_a/alu_b/alu_ctrl)
//  alu_car    in   1    ALU carry
//  alu_of     in   1    ALU overflow
//  res_q      out  W    captured result
//  car_q      out  1    captured carry
//  of_q       out  1    captured overflow
//  res_valid  out  1    res_q/car_q/of_q hold the result of the current operands
//  state_o    out  3    current FSM state code, for LEDs
// BEHAVIOUR
//  - Reset: all outputs 0, state S_A, synchronisers/debounce counters/debounced levels 0.
//  - Key path: raw key -> 2-flop synchroniser -> debouncer. Counter increments every cycle
//    synced level != debounced level, else clears; at DEB_CYCLES consecutive differing
//    cycles, debounced level flips and counter clears. press = 1-cycle pulse in the cycle
//    after debounced level goes 0->1. Releases produce no pulse. Glitches < DEB_CYCLES ignored.
//  - A key held through reset yields exactly one press, DEB_CYCLES+3 cycles after rst falls.
//  - FSM (state_o codes): S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4.
//    S_A   : next_press -> alu_a<=sw, res_valid<=0, -> S_B
//    S_B   : next_press -> alu_b<=sw, -> S_OP
//    S_OP  : next_press -> alu_ctrl<=op_sw, -> S_EXEC
//    S_EXEC: unconditional, 1 cycle (ALU settles on registered inputs);
//            res_q/car_q/of_q<=alu_res/alu_car/alu_of, res_valid<=1, -> S_SHOW
//    S_SHOW: next_press -> S_A (operands and result retained until overwritten)
//  - Latency: res_valid rises 2 cycles after the opcode press pulse.
//  - clr_press in any state: alu_a/alu_b/alu_ctrl/res_q/car_q/of_q<=0, res_valid<=0, -> S_A.
//    Simultaneous clr_press and next_press: clear wins, next is dropped.
//  - next_press arriving during S_EXEC is dropped (no queuing).
//  - Reset mid-sequence: identical to power-on reset; partial operands discarded.
//  - Switch values sampled only on the press-pulse cycle; no width extension, no arithmetic.
//  - Illegal state code: recover to S_A with clear semantics.
// STRUCTURE
//  - Package alu_seq_pkg: state codes S_A..S_SHOW, opcode constants OP_ADD=0, OP_SUB=1,
//    OP_NOT=2, OP_AND=3, OP_OR=4, OP_XOR=5, OP_LT=6, OP_EQ=7, default W/OPW.
//  - Sub-module key_debounce (sync + counter + edge pulse), instantiated for key_next, key_clr.
//  - Top: FSM plus operand/result registers; ALU instantiated by the parent, not here.
// TESTING (DEB_CYCLES=4, bench ALU model per opcode table)
//  - A: sw=3, B: sw=5, op=OP_ADD -> alu_a=3, alu_b=5, res_q=8, car_q=0, of_q=1, res_valid=1, state_o=4.
//  - A=4'hF, B=4'h1, op=OP_ADD -> res_q=0, car_q=1, of_q=0; then next press -> state_o=0, res_q still 0, res_valid=0 after next A press.
//  - key_next glitch high for 3 cycles -> no press, state_o stays 0; high for 6 cycles -> exactly one press.
//  - In S_OP with alu_a=2,alu_b=7, key_clr press -> all operands 0, state_o=0, res_valid=0.
//  - key_next and key_clr raised same cycle in S_B -> ends in S_A, alu_a=0, no B load.
//  - rst asserted 1 cycle during S_EXEC -> res_valid=0, res_q=0, state_o=0 next cycle.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared state codes, opcode constants and default widths for the ALU entry sequencer.
// No timing or flow control here: it holds only types and constants.
package alu_seq_pkg;

  localparam int W_DEF   = 4;
  localparam int OPW_DEF = 3;

  // Codes are shown directly on the board LEDs, so keep them fixed.
  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  localparam logic [OPW_DEF-1:0] OP_ADD = 3'd0;
  localparam logic [OPW_DEF-1:0] OP_SUB = 3'd1;
  localparam logic [OPW_DEF-1:0] OP_NOT = 3'd2;
  localparam logic [OPW_DEF-1:0] OP_AND = 3'd3;
  localparam logic [OPW_DEF-1:0] OP_OR  = 3'd4;
  localparam logic [OPW_DEF-1:0] OP_XOR = 3'd5;
  localparam logic [OPW_DEF-1:0] OP_LT  = 3'd6;
  localparam logic [OPW_DEF-1:0] OP_EQ  = 3'd7;

endpackage

// File: rtl/alu_input_seq_debounce.sv
// Raw button -> 2-flop sync -> level debouncer -> one-cycle press pulse on accepted 0->1.
// Latency: 2 sync cycles + DEB_CYCLES, pulse one cycle after the level flips; no backpressure.
module key_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= key;
      sync2   <= sync1;
      level_d <= level;
      // Any cycle where the synced key agrees with the accepted level restarts the count.
      if (sync2 != level) begin
        if (cnt == CW'(DEB_CYCLES - 1)) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/alu_input_seq.sv
// Key-driven A/B/opcode entry for the board ALU, capturing its result one cycle after ctrl loads.
// Latency: res_valid 2 cycles after the opcode press; presses during S_EXEC are dropped, never queued.
module alu_input_seq
  import alu_seq_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int OPW        = OPW_DEF,
  parameter int DEB_CYCLES = 2**20
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   sw,
  input  logic [OPW-1:0] op_sw,
  input  logic           key_next,
  input  logic           key_clr,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_ctrl,
  input  logic [W-1:0]   alu_res,
  input  logic           alu_car,
  input  logic           alu_of,
  output logic [W-1:0]   res_q,
  output logic           car_q,
  output logic           of_q,
  output logic           res_valid,
  output logic [2:0]     state_o
);

  logic   next_press;
  logic   clr_press;
  state_t state;
  state_t state_nxt;
  logic   ld_a;
  logic   ld_b;
  logic   ld_op;
  logic   cap;
  logic   clr;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .clk   (clk),
    .rst   (rst),
    .key   (key_next),
    .press (next_press)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .clk   (clk),
    .rst   (rst),
    .key   (key_clr),
    .press (clr_press)
  );

  always_comb begin
    state_nxt = state;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    ld_op     = 1'b0;
    cap       = 1'b0;
    clr       = 1'b0;
    if (clr_press) begin
      clr       = 1'b1;
      state_nxt = S_A;
    end else begin
      unique case (state)
        S_A:    if (next_press) begin ld_a  = 1'b1; state_nxt = S_B;    end
        S_B:    if (next_press) begin ld_b  = 1'b1; state_nxt = S_OP;   end
        S_OP:   if (next_press) begin ld_op = 1'b1; state_nxt = S_EXEC; end
        S_EXEC: begin cap = 1'b1; state_nxt = S_SHOW; end
        S_SHOW: if (next_press) state_nxt = S_A;
        default: begin clr = 1'b1; state_nxt = S_A; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_A;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctrl  <= '0;
      res_q     <= '0;
      car_q     <= 1'b0;
      of_q      <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clr) begin
        alu_a     <= '0;
        alu_b     <= '0;
        alu_ctrl  <= '0;
        res_q     <= '0;
        car_q     <= 1'b0;
        of_q      <= 1'b0;
        res_valid <= 1'b0;
      end
      // A new A operand invalidates the shown result; old result stays visible until then.
      if (ld_a) begin
        alu_a     <= sw;
        res_valid <= 1'b0;
      end
      if (ld_b)  alu_b    <= sw;
      if (ld_op) alu_ctrl <= op_sw;
      if (cap) begin
        res_q     <= alu_res;
        car_q     <= alu_car;
        of_q      <= alu_of;
        res_valid <= 1'b1;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_alu_input_seq.sv
// Self-checking bench: opcode vector table, directed corner sequences, randomized key traffic vs model.
module tb_alu_input_seq;
  import alu_seq_pkg::*;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic [2:0] op_sw;
  logic       key_next;
  logic       key_clr;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_ctrl;
  logic [3:0] alu_res;
  logic       alu_car;
  logic       alu_of;
  logic [3:0] res_q;
  logic       car_q;
  logic       of_q;
  logic       res_valid;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_input_seq #(.W(4), .OPW(3), .DEB_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .op_sw     (op_sw),
    .key_next  (key_next),
    .key_clr   (key_clr),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctrl  (alu_ctrl),
    .alu_res   (alu_res),
    .alu_car   (alu_car),
    .alu_of    (alu_of),
    .res_q     (res_q),
    .car_q     (car_q),
    .of_q      (of_q),
    .res_valid (res_valid),
    .state_o   (state_o)
  );

  // Board ALU stand-in; returns {carry, overflow, result}.
  function automatic logic [5:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    logic [4:0] s;
    logic [3:0] r;
    logic       c;
    logic       o;
    c = 1'b0;
    o = 1'b0;
    case (op)
      OP_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; o = (a[3] == b[3]) && (r[3] != a[3]); end
      OP_SUB: begin r = a - b; c = (a < b); o = (a[3] != b[3]) && (r[3] != a[3]); end
      OP_NOT: r = ~a;
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_LT:  r = (a < b) ? 4'd1 : 4'd0;
      default: r = (a == b) ? 4'd1 : 4'd0;
    endcase
    return {c, o, r};
  endfunction

  always_comb {alu_car, alu_of, alu_res} = alu_f(alu_a, alu_b, alu_ctrl);

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Hold the key(s) long enough to debounce, then release long enough to debounce back.
  task automatic press(input logic nxt, input logic clr);
    @(posedge clk); #1;
    key_next = nxt;
    key_clr  = clr;
    repeat (DEB + 3) @(posedge clk);
    #1;
    key_next = 1'b0;
    key_clr  = 1'b0;
    repeat (DEB + 5) @(posedge clk);
    #1;
  endtask

  task automatic pulse_next(input int n);
    @(posedge clk); #1;
    key_next = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    key_next = 1'b0;
    repeat (DEB + 8) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] res;
    logic       car;
    logic       of;
  } vec_t;

  vec_t tbl[10];

  // Sequence model: step 0..3 = waiting for A, B, opcode, showing result.
  int         m_step;
  logic [3:0] m_a, m_b, m_res;
  logic [2:0] m_op;
  logic       m_car, m_of, m_valid;
  logic [2:0] step_code[4];

  task automatic model_clear();
    m_step = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_car = 0; m_of = 0; m_valid = 0;
  endtask

  task automatic model_next(input logic [3:0] s, input logic [2:0] o);
    case (m_step)
      0: begin m_a = s; m_valid = 1'b0; m_step = 1; end
      1: begin m_b = s; m_step = 2; end
      2: begin m_op = o; {m_car, m_of, m_res} = alu_f(m_a, m_b, o); m_valid = 1'b1; m_step = 3; end
      default: m_step = 0;
    endcase
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_state"}, 8'(state_o), 8'(step_code[m_step]));
    chk({tag, "_a"}, 8'(alu_a), 8'(m_a));
    chk({tag, "_b"}, 8'(alu_b), 8'(m_b));
    chk({tag, "_ctrl"}, 8'(alu_ctrl), 8'(m_op));
    chk({tag, "_res"}, {2'b0, car_q, of_q, res_q}, {2'b0, m_car, m_of, m_res});
    chk({tag, "_valid"}, 8'(res_valid), 8'(m_valid));
  endtask

  initial begin
    logic       seen;
    logic [3:0] s;
    logic [2:0] o;

    step_code[0] = 3'd0; step_code[1] = 3'd1; step_code[2] = 3'd2; step_code[3] = 3'd4;
    tbl[0] = '{4'h3, 4'h5, OP_ADD, 4'h8, 1'b0, 1'b1};
    tbl[1] = '{4'hF, 4'h1, OP_ADD, 4'h0, 1'b1, 1'b0};
    tbl[2] = '{4'h7, 4'h2, OP_SUB, 4'h5, 1'b0, 1'b0};
    tbl[3] = '{4'h2, 4'h7, OP_SUB, 4'hB, 1'b1, 1'b0};
    tbl[4] = '{4'h8, 4'h1, OP_SUB, 4'h7, 1'b0, 1'b1};
    tbl[5] = '{4'h5, 4'h0, OP_NOT, 4'hA, 1'b0, 1'b0};
    tbl[6] = '{4'hC, 4'hA, OP_AND, 4'h8, 1'b0, 1'b0};
    tbl[7] = '{4'hC, 4'hA, OP_XOR, 4'h6, 1'b0, 1'b0};
    tbl[8] = '{4'h3, 4'h9, OP_LT,  4'h1, 1'b0, 1'b0};
    tbl[9] = '{4'h6, 4'h6, OP_EQ,  4'h1, 1'b0, 1'b0};

    rst = 1'b1; sw = 4'h9; op_sw = 3'd5; key_next = 1'b0; key_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 8'(state_o), 8'd0);
    chk("rst_regs", {alu_a, alu_b}, 8'h00);
    chk("rst_res", {1'b0, alu_ctrl, res_q}, 8'h00);
    chk("rst_flags", {5'b0, car_q, of_q, res_valid}, 8'h00);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Short glitch is rejected; a long-enough hold gives exactly one press.
    sw = 4'hA;
    pulse_next(3);
    chk("glitch3_state", 8'(state_o), 8'd0);
    pulse_next(6);
    chk("hold6_state", 8'(state_o), 8'd1);
    chk("hold6_a", 8'(alu_a), 8'h0A);
    press(1'b0, 1'b1);
    chk("clrA_state", 8'(state_o), 8'd0);

    for (int i = 0; i < 10; i++) begin
      sw = tbl[i].a;  press(1'b1, 1'b0);
      chk($sformatf("tbl%0d_valid_drop", i), 8'(res_valid), 8'd0);
      sw = tbl[i].b;  press(1'b1, 1'b0);
      op_sw = tbl[i].op; sw = 4'h0; press(1'b1, 1'b0);
      chk($sformatf("tbl%0d_ops", i), {alu_a, alu_b}, {tbl[i].a, tbl[i].b});
      chk($sformatf("tbl%0d_res", i), {2'b0, car_q, of_q, res_q}, {2'b0, tbl[i].car, tbl[i].of, tbl[i].res});
      chk($sformatf("tbl%0d_show", i), {4'b0, res_valid, state_o}, {4'b0, 1'b1, 3'd4});
      press(1'b1, 1'b0);
      chk($sformatf("tbl%0d_back", i), {state_o, res_valid, res_q}, {3'd0, 1'b1, tbl[i].res});
    end

    // Clear from S_OP wipes operands.
    sw = 4'h2; press(1'b1, 1'b0);
    sw = 4'h7; press(1'b1, 1'b0);
    chk("op_state", 8'(state_o), 8'd2);
    press(1'b0, 1'b1);
    chk("clrOP_ops", {alu_a, alu_b}, 8'h00);
    chk("clrOP_st", {4'b0, res_valid, state_o}, 8'h00);

    // Next and clear together in S_B: clear wins, B not loaded.
    sw = 4'h9; press(1'b1, 1'b0);
    sw = 4'h6; press(1'b1, 1'b1);
    chk("both_state", 8'(state_o), 8'd0);
    chk("both_ops", {alu_a, alu_b}, 8'h00);

    model_clear();
    for (int i = 0; i < 50; i++) begin
      s = 4'($urandom);
      o = 3'($urandom);
      sw = s;
      op_sw = o;
      if ($urandom_range(0, 4) == 0) begin
        press(1'b0, 1'b1);
        model_clear();
      end else begin
        press(1'b1, 1'b0);
        model_next(s, o);
      end
      check_model($sformatf("rnd%0d", i));
    end

    // Reset while in S_EXEC.
    press(1'b0, 1'b1);
    sw = 4'h6; press(1'b1, 1'b0);
    sw = 4'h3; press(1'b1, 1'b0);
    op_sw = OP_ADD;
    key_next = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(posedge clk); #1;
      if (state_o == 3'd3) seen = 1'b1;
    end
    chk("exec_reached", 8'(seen), 8'd1);
    if (seen) begin
      rst = 1'b1;
      key_next = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rstexec_st", {4'b0, res_valid, state_o}, 8'h00);
      chk("rstexec_res", {1'b0, car_q, of_q, 1'b0, res_q}, 8'h00);
      chk("rstexec_ops", {alu_a, alu_b}, 8'h00);
      repeat (DEB + 8) @(posedge clk);
      #1;
      chk("rstexec_idle", 8'(state_o), 8'd0);
    end
    key_next = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
